sprite_blitter: RTL and testbench

- Upstream producer for the SRAM frame-buffer controller. Drives its program_x / program_y / program_data write bus.
- Pops sprite draw commands from an internal FIFO and walks each sprite pixel by pixel, reading colour from an external sprite ROM.
- Each opaque, on-screen pixel is presented to the controller's program write slots, which draw into the hidden frame.
- Transparent and clipped pixels are redirected to an off-screen park address. The controller writes unconditionally, so this is how they are discarded.

---
 rtl/blitter_pkg.sv | 24 ++
 rtl/blit_cmd_fifo.sv | 50 +++++
 rtl/sprite_blitter.sv | 163 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blitter_pkg.sv
// Shared types for the sprite blitter: FSM states, screen bounds and the queued draw command.
// The command entry carries a flip bit only when SPRITE_FLIP_EN is defined.
package blitter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, PRESENT, PARK} blit_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CMD_ID_W = 4;

    typedef struct packed {
        logic [10:0]         x;
        logic [10:0]         y;
        logic [CMD_ID_W-1:0] id;
`ifdef SPRITE_FLIP_EN
        logic                flip;
`endif
    } blit_cmd_t;

    function automatic logic on_screen(input logic [10:0] sx, input logic [10:0] sy);
        return !sx[10] && !sy[10] && (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));
    endfunction

endpackage

// File: rtl/blit_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO with flush.
// A push coincident with flush is kept as the sole surviving entry.
module blit_cmd_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [7:0]
) (
    input  logic   sram_clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   push,
    input  entry_t wr_data,
    input  logic   pop,
    output entry_t rd_data,
    output logic   full,
    output logic   empty
);
    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge sram_clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            wr_ptr <= wr_ptr + PW'(do_push);
            count  <= (PW+1)'(do_push);
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: pops draw commands and feeds one pixel per two-cycle write slot to the
// frame-buffer controller. Optional horizontal mirroring via SPRITE_FLIP_EN.
module sprite_blitter
    import blitter_pkg::*;
#(
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          ID_W        = 4,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] TRANSPARENT = 16'h0000,
    parameter logic [9:0]  PARK_X      = 10'd1023,
    parameter logic [9:0]  PARK_Y      = 10'd511
) (
    input  logic                                          sram_clk,
    input  logic                                          reset,
    input  logic                                          frame_clk,
    input  logic                                          cmd_valid,
    output logic                                          cmd_ready,
    input  logic [10:0]                                   cmd_x,
    input  logic [10:0]                                   cmd_y,
    input  logic [ID_W-1:0]                               cmd_id,
    input  logic                                          cmd_flip,
    output logic [ID_W+$clog2(SPR_H)+$clog2(SPR_W)-1:0]   rom_addr,
    input  logic [15:0]                                   rom_data,
    output logic [9:0]                                    program_x,
    output logic [9:0]                                    program_y,
    output logic [15:0]                                   program_data,
    output logic                                          busy,
    output logic                                          overrun
);
    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    blit_state_e state, state_n;
    logic        ph;
    logic [2:0]  fsync;
    logic        frame_edge;
    blit_cmd_t   wr_cmd, rd_cmd, cur;
    logic        full, empty, push, pop;
    logic [RW-1:0] row;
    logic [CW-1:0] col, col_m;
    logic [10:0] sx, sy;
    logic        last_px;

    assign frame_edge = fsync[1] && !fsync[2];
    assign cmd_ready  = !full;
    assign push       = cmd_valid && cmd_ready;
    assign busy       = (state != IDLE) || !empty;
    assign last_px    = (row == RW'(SPR_H-1)) && (col == CW'(SPR_W-1));

    always_comb begin
        wr_cmd    = '0;
        wr_cmd.x  = cmd_x;
        wr_cmd.y  = cmd_y;
        wr_cmd.id = CMD_ID_W'(cmd_id);
`ifdef SPRITE_FLIP_EN
        wr_cmd.flip = cmd_flip;
`endif
    end

`ifdef SPRITE_FLIP_EN
    assign col_m = cur.flip ? CW'(SPR_W-1) - col : col;
`else
    logic unused_flip;
    assign unused_flip = cmd_flip;
    assign col_m       = col;
`endif

    blit_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (blit_cmd_t)
    ) u_fifo (
        .sram_clk (sram_clk),
        .reset    (reset),
        .flush    (frame_edge),
        .push     (push),
        .wr_data  (wr_cmd),
        .pop      (pop),
        .rd_data  (rd_cmd),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE:    if (!empty) begin pop = 1'b1; state_n = ISSUE; end
            ISSUE:   state_n = PRESENT;
            PRESENT: begin
                if (!last_px)     state_n = ISSUE;
                else if (!empty)  begin pop = 1'b1; state_n = ISSUE; end
                else              state_n = PARK;
            end
            PARK:    if (ph) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (frame_edge) begin
            state_n = IDLE;
            pop     = 1'b0;
        end
    end

    // PARK holds the last pixel through its second cycle, then parks on the next slot edge
    always_ff @(posedge sram_clk) begin
        if (reset) begin
            fsync        <= '0;
            state        <= IDLE;
            ph           <= 1'b0;
            cur          <= '0;
            row          <= '0;
            col          <= '0;
            sx           <= '0;
            sy           <= '0;
            rom_addr     <= '0;
            program_x    <= PARK_X;
            program_y    <= PARK_Y;
            program_data <= '0;
            overrun      <= 1'b0;
        end else begin
            fsync <= {fsync[1:0], frame_clk};
            state <= state_n;
            ph    <= (state == IDLE || frame_edge) ? 1'b0 : ~ph;
            case (state)
                ISSUE: begin
                    rom_addr <= {ID_W'(cur.id), row, col_m};
                    sx       <= cur.x + 11'(col);
                    sy       <= cur.y + 11'(row);
                end
                PRESENT: begin
                    if (rom_data != TRANSPARENT && on_screen(sx, sy)) begin
                        program_x <= sx[9:0];
                        program_y <= sy[9:0];
                    end else begin
                        program_x <= PARK_X;
                        program_y <= PARK_Y;
                    end
                    program_data <= rom_data;
                    col <= col + CW'(1);
                    if (col == CW'(SPR_W-1)) row <= row + RW'(1);
                end
                PARK: if (ph) begin
                    program_x    <= PARK_X;
                    program_y    <= PARK_Y;
                    program_data <= '0;
                end
                default: ;
            endcase
            if (pop) begin
                cur <= rd_cmd;
                row <= '0;
                col <= '0;
            end
            if (frame_edge) begin
                program_x    <= PARK_X;
                program_y    <= PARK_Y;
                program_data <= '0;
                if (busy) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter; flip check is built only with SPRITE_FLIP_EN.
module tb_sprite_blitter;

    logic        sram_clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [10:0] cmd_x = '0;
    logic [10:0] cmd_y = '0;
    logic [3:0]  cmd_id = '0;
    logic        cmd_flip = 1'b0;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic [9:0]  program_x, program_y;
    logic [15:0] program_data;
    logic        busy, overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int rom_mode = 0;

    always #5 sram_clk = ~sram_clk;

    // Mode 0: constant red; 1: even columns transparent; 2: colour encodes the address
    always_comb begin
        case (rom_mode)
            0:       rom_data = 16'hF800;
            1:       rom_data = rom_addr[0] ? (16'h8000 | 16'(rom_addr)) : 16'h0000;
            default: rom_data = 16'h8000 | 16'(rom_addr);
        endcase
    end

    sprite_blitter dut (
        .sram_clk     (sram_clk),
        .reset        (reset),
        .frame_clk    (frame_clk),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_id       (cmd_id),
        .cmd_flip     (cmd_flip),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .program_x    (program_x),
        .program_y    (program_y),
        .program_data (program_data),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic tick();
        @(posedge sram_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input int x, input int y, input int id);
        cmd_x     = 11'(x);
        cmd_y     = 11'(y);
        cmd_id    = 4'(id);
        cmd_flip  = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_parked(input string tag);
        chk({tag, "_px"}, 32'(program_x), 32'd1023);
        chk({tag, "_py"}, 32'(program_y), 32'd511);
        chk({tag, "_pd"}, 32'(program_data), 32'd0);
    endtask

    // Walk pixels lo..hi starting just after pixel lo was written; each must hold 2 cycles
    task automatic walk(input int x0, input int y0, input int id, input int lo, input int hi,
                        output int bad, output int vis);
        bad = 0;
        vis = 0;
        for (int p = lo; p <= hi; p++) begin
            int r, c, sx, sy, addr;
            logic [15:0] d;
            logic [9:0]  ex, ey;
            r = p / 32;
            c = p % 32;
            sx = x0 + c;
            sy = y0 + r;
            addr = (id << 10) | (r << 5) | c;
            case (rom_mode)
                0:       d = 16'hF800;
                1:       d = (c % 2 == 1) ? 16'(32'h8000 | addr) : 16'h0000;
                default: d = 16'(32'h8000 | addr);
            endcase
            if (d != 16'h0000 && sx >= 0 && sx < 640 && sy >= 0 && sy < 480) begin
                ex = 10'(sx);
                ey = 10'(sy);
                vis++;
            end else begin
                ex = 10'd1023;
                ey = 10'd511;
            end
            for (int h = 0; h < 2; h++) begin
                if (program_x !== ex || program_y !== ey || program_data !== d) bad++;
                tick();
            end
        end
    endtask

    initial begin
        int bad, vis;
        repeat (3) tick();
        reset = 1'b0;

        chk_parked("reset");
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd1);

        // Single opaque sprite: latency, hold, then park
        rom_mode = 0;
        push1(100, 50, 1);
        chk("s1_busy", 32'(busy), 32'd1);
        tick();
        tick();
        chk("s1_rom_addr", 32'(rom_addr), 32'd1024);
        chk("s1_not_yet", 32'(program_x), 32'd1023);
        tick();
        walk(100, 50, 1, 0, 1023, bad, vis);
        chk("s1_pixels", 32'(bad), 32'd0);
        chk("s1_visible", 32'(vis), 32'd1024);
        chk_parked("s1_end");
        chk("s1_idle", 32'(busy), 32'd0);

        // Clipped on left and bottom
        rom_mode = 2;
        push1(-8, 470, 5);
        repeat (3) tick();
        walk(-8, 470, 5, 0, 1023, bad, vis);
        chk("s2_pixels", 32'(bad), 32'd0);
        chk("s2_visible", 32'(vis), 32'd240);
        chk_parked("s2_end");

        // Transparent even columns
        rom_mode = 1;
        push1(200, 100, 2);
        repeat (3) tick();
        walk(200, 100, 2, 0, 1023, bad, vis);
        chk("s3_pixels", 32'(bad), 32'd0);
        chk("s3_visible", 32'(vis), 32'd512);

        // 17 back-to-back commands: one popped at once, 16 held
        rom_mode = 2;
        for (int i = 0; i < 17; i++) begin
            cmd_x     = 11'(i * 30);
            cmd_y     = 11'(i * 20);
            cmd_id    = 4'(i);
            cmd_valid = 1'b1;
            chk("s4_ready_before_push", 32'(cmd_ready), 32'd1);
            tick();
        end
        cmd_valid = 1'b0;
        chk("s4_ready_full", 32'(cmd_ready), 32'd0);
        chk("s4_busy", 32'(busy), 32'd1);
        tick();
        walk(0, 0, 0, 7, 1021, bad, vis);
        chk("s4_sp0_a", 32'(bad), 32'd0);
        chk("s4_ready_still_full", 32'(cmd_ready), 32'd0);
        walk(0, 0, 0, 1022, 1022, bad, vis);
        chk("s4_sp0_b", 32'(bad), 32'd0);
        chk("s4_ready_after_pop", 32'(cmd_ready), 32'd1);
        walk(0, 0, 0, 1023, 1023, bad, vis);
        chk("s4_sp0_c", 32'(bad), 32'd0);
        for (int i = 1; i < 17; i++) begin
            walk(i * 30, i * 20, i % 16, 0, 1023, bad, vis);
            chk("s4_sprite", 32'(bad), 32'd0);
        end
        chk_parked("s4_end");
        chk("s4_idle", 32'(busy), 32'd0);

        // Frame swap mid-sprite with a queued command: abort and flush
        push1(10, 10, 1);
        push1(50, 60, 2);
        tick();
        tick();
        walk(10, 10, 1, 0, 99, bad, vis);
        chk("s5_pre_pixels", 32'(bad), 32'd0);
        frame_clk = 1'b1;
        tick();
        tick();
        chk("s5_still_drawing", 32'(program_x), 32'd15);
        chk("s5_no_overrun_yet", 32'(overrun), 32'd0);
        tick();
        chk_parked("s5_abort");
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_overrun", 32'(overrun), 32'd1);
        frame_clk = 1'b0;
        repeat (4) tick();
        chk("s5_stays_idle", 32'(busy), 32'd0);

        // Frame swap with a push on the edge cycle: that command survives and is drawn
        push1(400, 300, 9);
        repeat (3) tick();
        walk(400, 300, 9, 0, 49, bad, vis);
        chk("s6_pre_pixels", 32'(bad), 32'd0);
        frame_clk = 1'b1;
        tick();
        tick();
        push1(600, 460, 12);
        chk_parked("s6_abort");
        chk("s6_busy_kept", 32'(busy), 32'd1);
        repeat (3) tick();
        walk(600, 460, 12, 0, 1023, bad, vis);
        chk("s6_pixels", 32'(bad), 32'd0);
        chk("s6_visible", 32'(vis), 32'd640);
        chk_parked("s6_end");
        chk("s6_overrun_sticky", 32'(overrun), 32'd1);
        frame_clk = 1'b0;

`ifdef SPRITE_FLIP_EN
        cmd_x     = 11'd0;
        cmd_y     = 11'd0;
        cmd_id    = 4'd0;
        cmd_flip  = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_flip  = 1'b0;
        tick();
        tick();
        chk("flip_col0", 32'(rom_addr[4:0]), 32'd31);
        repeat (2050) tick();
        chk("flip_done", 32'(busy), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
